row_clear_engine: RTL and testbench

//  Consumes the full-row mask for the 20x10 playfield and removes every full row.

---
 rtl/row_clear_engine_pkg.sv | 17 +
 rtl/row_mask_msb.sv | 18 +
 rtl/row_clear_engine.sv | 111 +++++++++++
 tb/tb_row_clear_engine.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/row_clear_engine_pkg.sv
// Shared constants and FSM encoding for the row clear engine.
// Playfield geometry: row 0 is the bottom, row ROWS-1 is the top.
package row_clear_engine_pkg;

  localparam int unsigned ROWS  = 20;
  localparam int unsigned COLS  = 10;
  localparam int unsigned IDX_W = 5;

  typedef enum logic [2:0] {
    StIdle,
    StPick,
    StShift,
    StTop,
    StDone
  } state_e;

endpackage

// File: rtl/row_mask_msb.sv
// Combinational priority encoder: index of the highest set bit of a ROWS-wide mask.
// Returns 0 for an all-zero mask; the caller qualifies with its own zero test.
module row_mask_msb
  import row_clear_engine_pkg::*;
(
  input  logic [ROWS-1:0]  mask_i,
  output logic [IDX_W-1:0] idx_o
);

  // Later iterations win, so the highest set bit ends up in idx_o.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (mask_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/row_clear_engine.sv
// Removes every full row from the playfield, highest first, shifting the rows above
// each cleared row down by one and zero-filling the top row.
module row_clear_engine
  import row_clear_engine_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [ROWS-1:0]  full_rows,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] lines_cleared,
  output logic [IDX_W-1:0] rd_addr,
  input  logic [COLS-1:0]  rd_data,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_addr,
  output logic [COLS-1:0]  wr_data
);

  state_e           state_q, state_d;
  logic [ROWS-1:0]  mask_q, mask_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [IDX_W-1:0] r_q, r_d;
  logic [IDX_W-1:0] lines_q, lines_d;
  logic [IDX_W-1:0] msb_idx;

  row_mask_msb u_msb (
    .mask_i (mask_q),
    .idx_o  (msb_idx)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      mask_q  <= '0;
      k_q     <= '0;
      r_q     <= '0;
      lines_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      k_q     <= k_d;
      r_q     <= r_d;
      lines_q <= lines_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    k_d     = k_q;
    r_d     = r_q;
    lines_d = lines_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mask_d  = full_rows;
          lines_d = '0;
          state_d = StPick;
        end
      end
      StPick: begin
        if (mask_q == '0) begin
          state_d = StDone;
        end else begin
          k_d     = msb_idx;
          r_d     = msb_idx;
          // The top row has nothing above it to shift down.
          state_d = (msb_idx < IDX_W'(ROWS - 1)) ? StShift : StTop;
        end
      end
      StShift: begin
        r_d = r_q + IDX_W'(1);
        if (r_q == IDX_W'(ROWS - 2)) state_d = StTop;
      end
      StTop: begin
        mask_d[k_q] = 1'b0;
        lines_d     = lines_q + IDX_W'(1);
        state_d     = StPick;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode from state and registered counters; wr_data passes the
  // combinational board read straight through while shifting.
  always_comb begin
    busy          = (state_q != StIdle);
    done          = (state_q == StDone);
    lines_cleared = lines_q;
    wr_en         = 1'b0;
    rd_addr       = '0;
    wr_addr       = '0;
    wr_data       = '0;
    if (state_q == StShift) begin
      wr_en   = 1'b1;
      rd_addr = r_q + IDX_W'(1);
      wr_addr = r_q;
      wr_data = rd_data;
    end else if (state_q == StTop) begin
      wr_en   = 1'b1;
      wr_addr = IDX_W'(ROWS - 1);
    end
  end

endmodule

// File: tb/tb_row_clear_engine.sv
// Bench for row_clear_engine: 20x10 board model with combinational read, a table of
// directed vectors, and hand sequences for start-while-busy and mid-run reset.
module tb_row_clear_engine;
  import row_clear_engine_pkg::*;

  logic             clk = 1'b0;
  logic             resetn;
  logic             start;
  logic [ROWS-1:0]  full_rows;
  logic             busy, done, wr_en;
  logic [IDX_W-1:0] lines_cleared, rd_addr, wr_addr;
  logic [COLS-1:0]  rd_data, wr_data;

  logic [COLS-1:0]  board [ROWS];
  logic             init_req = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  row_clear_engine dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .full_rows     (full_rows),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data)
  );

  assign rd_data = (rd_addr < IDX_W'(ROWS)) ? board[rd_addr] : '0;

  // Board register file; init_req loads row i with value i.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < ROWS; i++) board[i] <= COLS'(i);
    end else if (wr_en && (wr_addr < IDX_W'(ROWS))) begin
      board[wr_addr] <= wr_data;
    end
  end

  typedef struct {
    string           name;
    logic [ROWS-1:0] mask;
    int              lat;
    int              lines;
    int              writes;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Expected final row j: surviving rows of the initial board, compacted downward.
  function automatic int exp_row(input logic [ROWS-1:0] m, input int j);
    int n = 0;
    for (int i = 0; i < ROWS; i++) begin
      if (!m[i]) begin
        if (n == j) return i;
        n++;
      end
    end
    return 0;
  endfunction

  // Loads the board, issues start, and counts cycles from the start-sampling edge.
  task automatic run_op(input logic [ROWS-1:0] m, input int glitch_cyc,
                        output int lat, output int writes);
    @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req  = 1'b0;
    start     = 1'b1;
    full_rows = m;
    @(posedge clk);
    #1;
    start     = 1'b0;
    full_rows = '0;
    lat       = -1;
    writes    = 0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (wr_en) writes++;
      if (cyc == glitch_cyc) begin
        start     = 1'b1;
        full_rows = '1;
      end else begin
        start     = 1'b0;
        full_rows = '0;
      end
      if (done) begin
        lat = cyc;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_board(input string name, input logic [ROWS-1:0] m);
    for (int j = 0; j < ROWS; j++) begin
      check($sformatf("%s_row%0d", name, j), int'(board[j]), exp_row(m, j));
    end
  endtask

  initial begin
    int lat, writes;

    vecs[0] = '{"none",    20'h00000,   2,  0,   0};
    vecs[1] = '{"bottom",  20'h00001,  23,  1,  20};
    vecs[2] = '{"top",     20'h80000,   4,  1,   1};
    vecs[3] = '{"two",     20'h00005,  42,  2,  38};
    vecs[4] = '{"r18_r0",  20'h40001,  26,  2,  22};
    vecs[5] = '{"all",     20'hFFFFF, 232, 20, 210};

    resetn    = 1'b0;
    start     = 1'b0;
    full_rows = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  int'(busy), 0);
    check("rst_done",  int'(done), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_lines", int'(lines_cleared), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy",  int'(busy), 0);
    check("idle_done",  int'(done), 0);
    check("idle_wr_en", int'(wr_en), 0);

    for (int v = 0; v < 6; v++) begin
      run_op(vecs[v].mask, 0, lat, writes);
      check({vecs[v].name, "_latency"}, lat, vecs[v].lat);
      check({vecs[v].name, "_lines"}, int'(lines_cleared), vecs[v].lines);
      check({vecs[v].name, "_writes"}, writes, vecs[v].writes);
      @(negedge clk);
      check({vecs[v].name, "_busy_after"}, int'(busy), 0);
      check({vecs[v].name, "_lines_hold"}, int'(lines_cleared), vecs[v].lines);
      check_board(vecs[v].name, vecs[v].mask);
    end

    // Start pulse (with all-ones mask) on cycle 5 of a busy run must be ignored.
    run_op(20'h00005, 5, lat, writes);
    check("glitch_latency", lat, 42);
    check("glitch_lines", int'(lines_cleared), 2);
    check("glitch_writes", writes, 38);
    @(negedge clk);
    check("glitch_row0", int'(board[0]), 1);
    check("glitch_row1", int'(board[1]), 3);
    check("glitch_row2", int'(board[2]), 4);
    check("glitch_row17", int'(board[17]), 19);
    check("glitch_row18", int'(board[18]), 0);
    check("glitch_row19", int'(board[19]), 0);
    check("glitch_idle", int'(busy), 0);

    // Reset in the middle of SHIFT.
    @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req  = 1'b0;
    start     = 1'b1;
    full_rows = 20'h00001;
    @(posedge clk);
    #1;
    start     = 1'b0;
    full_rows = '0;
    repeat (5) @(negedge clk);
    check("midrst_pre_wr_en", int'(wr_en), 1);
    check("midrst_pre_busy", int'(busy), 1);
    resetn = 1'b0;
    #1;
    check("midrst_wr_en", int'(wr_en), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_lines", int'(lines_cleared), 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_idle_busy", int'(busy), 0);
    check("midrst_idle_wr_en", int'(wr_en), 0);

    run_op(20'h80000, 0, lat, writes);
    check("recover_latency", lat, 4);
    check("recover_lines", int'(lines_cleared), 1);
    check("recover_writes", writes, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
